// File: rtl/fbvar_check_batch_if.sv
// Avalon-MM read/write bus used by the framebuffer descriptor checker.
// master: the checker issuing reads/writes; slave: the memory side.
interface fbvar_check_batch_if;
  logic [63:0] avmm_0_rw_address;
  logic [7:0]  avmm_0_rw_byteenable;
  logic        avmm_0_rw_read;
  logic        avmm_0_rw_write;
  logic [63:0] avmm_0_rw_writedata;
  logic [63:0] avmm_0_rw_readdata;
  logic        avmm_0_rw_readdatavalid;
  logic        avmm_0_rw_waitrequest;

  modport master (
    output avmm_0_rw_address, avmm_0_rw_byteenable, avmm_0_rw_read,
           avmm_0_rw_write, avmm_0_rw_writedata,
    input  avmm_0_rw_readdata, avmm_0_rw_readdatavalid, avmm_0_rw_waitrequest
  );

  modport slave (
    input  avmm_0_rw_address, avmm_0_rw_byteenable, avmm_0_rw_read,
           avmm_0_rw_write, avmm_0_rw_writedata,
    output avmm_0_rw_readdata, avmm_0_rw_readdatavalid, avmm_0_rw_waitrequest
  );
endinterface

// File: rtl/fbvar_check_batch.sv
// Batch framebuffer var-screeninfo checker. Walks arg_count 24-byte
// descriptors starting at arg_base, validates resolution / bpp / vmode,
// writes a per-descriptor result word and returns the number of failures.
module fbvar_check_batch #(
  parameter int          MAX_XRES   = 1600,
  parameter int          MAX_YRES   = 1200,
  parameter logic [3:0]  BPP_EN     = 4'b1111,
  parameter int          ALIGN_LOG2 = 3
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        start,
  output logic        busy,
  output logic        done,
  input  logic        stall,
  output logic [31:0] returndata,
  input  logic [63:0] arg_base,
  input  logic [15:0] arg_count,
  input  logic [63:0] FB_VMODE_NONINTERLACED,
  fbvar_check_batch_if.master bus
);

  localparam logic [31:0] MAXX       = 32'(MAX_XRES);
  localparam logic [31:0] MAXY       = 32'(MAX_YRES);
  localparam logic [31:0] ALIGN_MASK = 32'((64'd1 << ALIGN_LOG2) - 64'd1);
  localparam logic [31:0] EINVAL_RET = 32'hFFFF_FFEA;

  typedef enum logic [3:0] {
    IDLE, RD0, W0, RD1, W1, CHECK, WR, NEXT, RET
  } state_t;

  state_t      state;
  logic [63:0] desc_addr;   // byte address of the current descriptor
  logic [15:0] count;
  logic [15:0] idx;
  logic [15:0] fail_cnt;
  logic [7:0]  vm_ref;
  logic [31:0] xres, yres, bpp;
  logic [7:0]  vmode;
  logic        pass_q;

  logic        bpp_ok, pass;
  logic [31:0] xres_virt;
  logic [15:0] fail_n;
  logic        more_n;

  // Only the low byte of the vmode argument and of the vmode field matter.
  logic unused_ok;
  assign unused_ok = ^{FB_VMODE_NONINTERLACED[63:8], bus.avmm_0_rw_readdata[63:40]};

  assign bus.avmm_0_rw_byteenable = 8'hFF;

  // Descriptor validation and aligned virtual width, consumed in CHECK.
  always_comb begin
    bpp_ok    = ((bpp == 32'd32) && BPP_EN[3]) ||
                ((bpp == 32'd24) && BPP_EN[2]) ||
                ((bpp == 32'd16) && BPP_EN[1]) ||
                ((bpp == 32'd8)  && BPP_EN[0]);
    pass      = bpp_ok &&
                (xres != 32'd0) && (xres <= MAXX) &&
                (yres != 32'd0) && (yres <= MAXY) &&
                (vmode == vm_ref);
    xres_virt = (xres + ALIGN_MASK) & ~ALIGN_MASK;
  end

  // Saturating fail count and loop-continue decision, consumed in NEXT.
  always_comb begin
    fail_n = fail_cnt;
    if (!pass_q && (fail_cnt != 16'hFFFF))
      fail_n = fail_cnt + 16'd1;
    more_n = ({1'b0, idx} + 17'd1) < {1'b0, count};
  end

  // Main sequencer: all bus and return outputs are registered here.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state                   <= IDLE;
      busy                    <= 1'b0;
      done                    <= 1'b0;
      returndata              <= 32'd0;
      bus.avmm_0_rw_address   <= 64'd0;
      bus.avmm_0_rw_read      <= 1'b0;
      bus.avmm_0_rw_write     <= 1'b0;
      bus.avmm_0_rw_writedata <= 64'd0;
      desc_addr               <= 64'd0;
      count                   <= 16'd0;
      idx                     <= 16'd0;
      fail_cnt                <= 16'd0;
      vm_ref                  <= 8'd0;
      xres                    <= 32'd0;
      yres                    <= 32'd0;
      bpp                     <= 32'd0;
      vmode                   <= 8'd0;
      pass_q                  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          desc_addr <= arg_base;
          count     <= arg_count;
          vm_ref    <= FB_VMODE_NONINTERLACED[7:0];
          fail_cnt  <= 16'd0;
          idx       <= 16'd0;
          busy      <= 1'b1;
          if (arg_count == 16'd0) begin
            state      <= RET;
            done       <= 1'b1;
            returndata <= 32'd0;
          end else begin
            state                 <= RD0;
            bus.avmm_0_rw_read    <= 1'b1;
            bus.avmm_0_rw_address <= arg_base;
          end
        end
        RD0: if (!bus.avmm_0_rw_waitrequest) begin
          bus.avmm_0_rw_read <= 1'b0;
          state              <= W0;
        end
        W0: if (bus.avmm_0_rw_readdatavalid) begin
          xres                  <= bus.avmm_0_rw_readdata[31:0];
          yres                  <= bus.avmm_0_rw_readdata[63:32];
          bus.avmm_0_rw_read    <= 1'b1;
          bus.avmm_0_rw_address <= desc_addr + 64'd8;
          state                 <= RD1;
        end
        RD1: if (!bus.avmm_0_rw_waitrequest) begin
          bus.avmm_0_rw_read <= 1'b0;
          state              <= W1;
        end
        W1: if (bus.avmm_0_rw_readdatavalid) begin
          bpp   <= bus.avmm_0_rw_readdata[31:0];
          vmode <= bus.avmm_0_rw_readdata[39:32];
          state <= CHECK;
        end
        CHECK: begin
          pass_q                  <= pass;
          bus.avmm_0_rw_write     <= 1'b1;
          bus.avmm_0_rw_address   <= desc_addr + 64'd16;
          bus.avmm_0_rw_writedata <= pass ? {xres_virt, 32'd0} : {32'd0, EINVAL_RET};
          state                   <= WR;
        end
        WR: if (!bus.avmm_0_rw_waitrequest) begin
          bus.avmm_0_rw_write <= 1'b0;
          state               <= NEXT;
        end
        NEXT: begin
          fail_cnt  <= fail_n;
          idx       <= idx + 16'd1;
          desc_addr <= desc_addr + 64'd24;
          if (more_n) begin
            state                 <= RD0;
            bus.avmm_0_rw_read    <= 1'b1;
            bus.avmm_0_rw_address <= desc_addr + 64'd24;
          end else begin
            state      <= RET;
            done       <= 1'b1;
            returndata <= {16'd0, fail_n};
          end
        end
        RET: if (!stall) begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fbvar_check_batch.sv
// Scoreboard bench for fbvar_check_batch: a memory slave model applies
// writes and checks them against expected (addr,data) pairs; a done
// monitor checks returndata against expected return values.
module tb_fbvar_check_batch;
  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic        busy, done;
  logic [31:0] returndata;
  logic [63:0] arg_base = 64'd0;
  logic [15:0] arg_count = 16'd0;
  logic [63:0] fbvm = 64'd0;

  fbvar_check_batch_if bus();

  fbvar_check_batch dut (
    .clock(clock), .resetn(resetn), .start(start), .busy(busy), .done(done),
    .stall(stall), .returndata(returndata), .arg_base(arg_base),
    .arg_count(arg_count), .FB_VMODE_NONINTERLACED(fbvm), .bus(bus)
  );

  always #5 clock = ~clock;

  int chk_cnt = 0;
  int pass_cnt = 0;

  logic [63:0]  mem [logic [63:0]];
  logic [127:0] exp_wr [$];
  logic [31:0]  exp_ret [$];

  int          ws_cfg = 0;
  int          rd_extra = 0;
  bit          rdv_rand = 1'b0;
  logic [63:0] trig_addr = '1;
  bit          trig_hit = 1'b0;
  int          req_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic fail_now(input string nm);
    chk_cnt++;
    $display("FAIL %s: got event missing expected event present", nm);
  endtask

  function automatic logic [63:0] rd_mem(input logic [63:0] a);
    if (mem.exists(a)) return mem[a];
    return 64'd0;
  endfunction

  task automatic set_desc(input logic [63:0] base, input int i, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] b, input logic [31:0] vm);
    logic [63:0] a;
    a = base + 64'(24 * i);
    mem[a]          = {y, x};
    mem[a + 64'd8]  = {vm, b};
    mem[a + 64'd16] = 64'h5A5A_5A5A_5A5A_5A5A;
  endtask

  task automatic exp_write(input logic [63:0] a, input logic [63:0] d);
    exp_wr.push_back({a, d});
  endtask

  // Memory slave model with programmable waitrequest and read latency.
  initial begin : slave
    bit          seen, rd_pend, cap_rd, cap_wr;
    int          ws_left, rd_dly;
    logic [63:0] cap_addr, cap_data, rd_addr;
    logic [127:0] e;
    seen = 0; rd_pend = 0; ws_left = 0; rd_dly = 0;
    cap_rd = 0; cap_wr = 0; cap_addr = 0; cap_data = 0; rd_addr = 0;
    bus.avmm_0_rw_waitrequest   = 1'b0;
    bus.avmm_0_rw_readdatavalid = 1'b0;
    bus.avmm_0_rw_readdata      = 64'd0;
    forever begin
      @(negedge clock);
      bus.avmm_0_rw_readdatavalid = 1'b0;
      if (!resetn) begin
        seen = 0;
        bus.avmm_0_rw_waitrequest = 1'b0;
      end
      if (bus.avmm_0_rw_read && bus.avmm_0_rw_write)
        chk("rd_wr_exclusive", 64'd1, 64'd0);
      if (rd_pend) begin
        if (rd_dly == 0) begin
          bus.avmm_0_rw_readdatavalid = 1'b1;
          bus.avmm_0_rw_readdata      = rd_mem(rd_addr);
          rd_pend = 0;
        end else rd_dly--;
      end else if (resetn && (bus.avmm_0_rw_read || bus.avmm_0_rw_write)) begin
        if (!seen) begin
          seen = 1; req_cnt++;
          cap_rd = bus.avmm_0_rw_read; cap_wr = bus.avmm_0_rw_write;
          cap_addr = bus.avmm_0_rw_address; cap_data = bus.avmm_0_rw_writedata;
          ws_left = ws_cfg;
        end else begin
          chk("stall_addr", bus.avmm_0_rw_address, cap_addr);
          chk("stall_rdwr", {62'd0, bus.avmm_0_rw_read, bus.avmm_0_rw_write}, {62'd0, cap_rd, cap_wr});
          if (cap_wr) chk("stall_wdata", bus.avmm_0_rw_writedata, cap_data);
        end
        if (ws_left > 0) begin
          bus.avmm_0_rw_waitrequest = 1'b1;
          ws_left--;
        end else begin
          bus.avmm_0_rw_waitrequest = 1'b0;
          seen = 0;
          chk("byteenable", {56'd0, bus.avmm_0_rw_byteenable}, 64'hFF);
          if (cap_wr) begin
            mem[cap_addr] = cap_data;
            if (exp_wr.size() == 0) fail_now("unexpected_write");
            else begin
              e = exp_wr.pop_front();
              chk("wr_addr", cap_addr, e[127:64]);
              chk("wr_data", cap_data, e[63:0]);
            end
          end else begin
            rd_pend = 1;
            rd_addr = cap_addr;
            rd_dly  = rd_extra + (rdv_rand ? int'($urandom_range(0, 3)) : 0);
            if (cap_addr == trig_addr) trig_hit = 1;
          end
        end
      end
    end
  end

  // Return monitor: each rising done pops one expected return value.
  initial begin : ret_mon
    logic done_q;
    done_q = 1'b0;
    forever begin
      @(negedge clock);
      if (done && !done_q) begin
        if (exp_ret.size() == 0) fail_now("unexpected_done");
        else chk("returndata", {32'd0, returndata}, {32'd0, exp_ret.pop_front()});
      end
      done_q = done;
    end
  end

  // Issue one call; exp_lat counts cycles from the accept edge to done (0 = skip).
  task automatic run_batch(input logic [63:0] base, input logic [15:0] cnt,
                           input logic [63:0] vm, input int stall_n,
                           input int exp_lat, input bit poke);
    int lat;
    bit got;
    logic [31:0] rd0;
    @(negedge clock);
    arg_base = base; arg_count = cnt; fbvm = vm;
    stall = (stall_n > 0);
    start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    lat = 0; got = 0;
    while (lat < 3000) begin
      @(negedge clock);
      lat++;
      if (poke && lat == 3) begin
        start = 1'b1; arg_count = 16'd0; arg_base = 64'h9999_0000; fbvm = 64'h77;
      end
      if (poke && lat == 4) start = 1'b0;
      if (done) begin got = 1; break; end
    end
    if (!got) fail_now("done_timeout");
    else begin
      if (exp_lat > 0) chk("latency", 64'(lat), 64'(exp_lat));
      rd0 = returndata;
      for (int k = 0; k < stall_n; k++) begin
        @(negedge clock);
        chk("stall_done", {63'd0, done}, 64'd1);
        chk("stall_ret", {32'd0, returndata}, {32'd0, rd0});
      end
      stall = 1'b0;
      @(negedge clock);
      chk("idle_busy", {62'd0, busy, done}, 64'd0);
      chk("wr_drained", 64'(exp_wr.size()), 64'd0);
    end
  endtask

  initial begin : stim
    int req0;
    bit got;
    // Reset state.
    repeat (2) @(negedge clock);
    chk("rst_ctl", {60'd0, busy, done, bus.avmm_0_rw_read, bus.avmm_0_rw_write}, 64'd0);
    chk("rst_addr", bus.avmm_0_rw_address, 64'd0);
    chk("rst_wdata", bus.avmm_0_rw_writedata, 64'd0);
    chk("rst_ret", {32'd0, returndata}, 64'd0);
    resetn = 1'b1;

    // Single passing descriptor, 16 bpp 1024x768.
    set_desc(64'h1000, 0, 32'd1024, 32'd768, 32'd16, 32'd0);
    exp_write(64'h1010, 64'h0000_0400_0000_0000);
    exp_ret.push_back(32'd0);
    run_batch(64'h1000, 16'd1, 64'd0, 0, 8, 0);

    // Three descriptors, middle has bpp=15; a stray start mid-run is ignored.
    set_desc(64'h2000, 0, 32'd800,  32'd600,  32'd32, 32'd0);
    set_desc(64'h2000, 1, 32'd800,  32'd600,  32'd15, 32'd0);
    set_desc(64'h2000, 2, 32'd1600, 32'd1200, 32'd8,  32'd0);
    exp_write(64'h2010, 64'h0000_0320_0000_0000);
    exp_write(64'h2028, 64'h0000_0000_FFFF_FFEA);
    exp_write(64'h2040, 64'h0000_0640_0000_0000);
    exp_ret.push_back(32'd1);
    run_batch(64'h2000, 16'd3, 64'd0, 0, 22, 1);

    // Range, alignment and vmode boundaries; only vmode[7:0] compared.
    set_desc(64'h3000, 0, 32'd1601, 32'd100,  32'd16, 32'd0);
    set_desc(64'h3000, 1, 32'd1001, 32'd1,    32'd24, 32'd0);
    set_desc(64'h3000, 2, 32'd640,  32'd480,  32'd32, 32'd1);
    set_desc(64'h3000, 3, 32'd640,  32'd0,    32'd8,  32'd0);
    set_desc(64'h3000, 4, 32'd1600, 32'd1200, 32'd8,  32'h1234_5600);
    exp_write(64'h3010, 64'h0000_0000_FFFF_FFEA);
    exp_write(64'h3028, 64'h0000_03F0_0000_0000);
    exp_write(64'h3040, 64'h0000_0000_FFFF_FFEA);
    exp_write(64'h3058, 64'h0000_0000_FFFF_FFEA);
    exp_write(64'h3070, 64'h0000_0640_0000_0000);
    exp_ret.push_back(32'd3);
    run_batch(64'h3000, 16'd5, 64'hABCD_0000_0000_0000, 0, 36, 0);

    // Same three-descriptor batch with 5-cycle waitrequest and random read latency.
    set_desc(64'h2000, 0, 32'd800,  32'd600,  32'd32, 32'd0);
    set_desc(64'h2000, 1, 32'd800,  32'd600,  32'd15, 32'd0);
    set_desc(64'h2000, 2, 32'd1600, 32'd1200, 32'd8,  32'd0);
    exp_write(64'h2010, 64'h0000_0320_0000_0000);
    exp_write(64'h2028, 64'h0000_0000_FFFF_FFEA);
    exp_write(64'h2040, 64'h0000_0640_0000_0000);
    exp_ret.push_back(32'd1);
    ws_cfg = 5; rdv_rand = 1'b1;
    run_batch(64'h2000, 16'd3, 64'd0, 0, 0, 0);
    ws_cfg = 0; rdv_rand = 1'b0;

    // Empty batch: no bus traffic, done next cycle, held under stall.
    req0 = req_cnt;
    exp_ret.push_back(32'd0);
    run_batch(64'h5000, 16'd0, 64'd0, 4, 1, 0);
    chk("empty_no_bus", 64'(req_cnt), 64'(req0));

    // Address wrap across the top of the 64-bit space.
    set_desc(64'hFFFF_FFFF_FFFF_FFF0, 0, 32'd640, 32'd480, 32'd16, 32'd0);
    set_desc(64'hFFFF_FFFF_FFFF_FFF0, 1, 32'd0,   32'd480, 32'd16, 32'd0);
    exp_write(64'h0000_0000_0000_0000, 64'h0000_0280_0000_0000);
    exp_write(64'h0000_0000_0000_0018, 64'h0000_0000_FFFF_FFEA);
    exp_ret.push_back(32'd1);
    run_batch(64'hFFFF_FFFF_FFFF_FFF0, 16'd2, 64'd0, 0, 15, 0);

    // Reset asserted while waiting on word1 of descriptor 2.
    set_desc(64'h4000, 0, 32'd200, 32'd100, 32'd32, 32'd0);
    set_desc(64'h4000, 1, 32'd9,   32'd10,  32'd8,  32'd0);
    set_desc(64'h4000, 2, 32'd640, 32'd480, 32'd16, 32'd0);
    exp_write(64'h4010, 64'h0000_00C8_0000_0000);
    exp_write(64'h4028, 64'h0000_0010_0000_0000);
    rd_extra = 3; trig_addr = 64'h4038; trig_hit = 1'b0;
    @(negedge clock);
    arg_base = 64'h4000; arg_count = 16'd3; fbvm = 64'd0;
    start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    got = 0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clock);
      if (trig_hit) begin got = 1; break; end
    end
    if (!got) fail_now("reset_trigger_timeout");
    @(posedge clock); #1 resetn = 1'b0;
    #1;
    chk("mid_rst_ctl", {60'd0, busy, done, bus.avmm_0_rw_read, bus.avmm_0_rw_write}, 64'd0);
    chk("mid_rst_addr", bus.avmm_0_rw_address, 64'd0);
    chk("mid_rst_wdata", bus.avmm_0_rw_writedata, 64'd0);
    chk("mid_rst_ret", {32'd0, returndata}, 64'd0);
    chk("mid_rst_writes", 64'(exp_wr.size()), 64'd0);
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    rd_extra = 0; trig_addr = '1;
    req0 = req_cnt;
    repeat (6) @(negedge clock);
    chk("post_rst_quiet", 64'(req_cnt), 64'(req0));
    chk("post_rst_busy", {63'd0, busy}, 64'd0);

    // Normal call after the abandoned one.
    set_desc(64'h1000, 0, 32'd1024, 32'd768, 32'd16, 32'd0);
    exp_write(64'h1010, 64'h0000_0400_0000_0000);
    exp_ret.push_back(32'd0);
    run_batch(64'h1000, 16'd1, 64'd0, 0, 8, 0);
    chk("ret_drained", 64'(exp_ret.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/fbvar_check_batch.md
FBVAR_CHECK_BATCH -- requirements
Module: fbvar_check_batch

Interface
REQ-001 Parameter MAX_XRES, default 1600: largest legal xres.
REQ-002 Parameter MAX_YRES, default 1200: largest legal yres.
REQ-003 Parameter BPP_EN, default 4'b1111: enable bits for bpp 32/24/16/8, MSB..LSB.
REQ-004 Parameter ALIGN_LOG2, default 3: xres_virtual is aligned to 2**ALIGN_LOG2 pixels.
REQ-005 clock  in  1  sole clock; all state updates on its rising edge.
REQ-006 resetn  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  call valid; accepted only in IDLE.
REQ-008 busy  out  1  call stall; high in every state except IDLE.
REQ-009 done  out  1  return valid.
REQ-010 stall  in  1  return stall from the caller.
REQ-011 returndata  out  32  count of failed descriptors.
REQ-012 arg_base  in  64  byte address of descriptor 0; sampled at call accept.
REQ-013 arg_count  in  16  number of descriptors; sampled at call accept.
REQ-014 FB_VMODE_NONINTERLACED  in  64  required vmode value, bits [7:0] used; sampled at call accept.
REQ-015 avmm_0_rw_address  out  64; avmm_0_rw_byteenable  out  8, constant 8'hFF; avmm_0_rw_read  out  1; avmm_0_rw_write  out  1; avmm_0_rw_writedata  out  64.
REQ-016 avmm_0_rw_readdata  in  64; avmm_0_rw_readdatavalid  in  1; avmm_0_rw_waitrequest  in  1.

Function
REQ-017 Descriptor i starts at arg_base + 24*i, 64-bit address arithmetic with wrap: word0 = {yres[63:32], xres[31:0]}; word1 = {vmode[63:32], bpp[31:0]}; word2 = result, written by the block.
REQ-018 FSM states: IDLE, RD0, W0, RD1, W1, CHECK, WR, NEXT, RET.
REQ-019 IDLE: start=1 latches the arguments, clears the fail counter and index, and enters RD0; if arg_count=0 it enters RET instead.
REQ-020 RD0/RD1: read=1 with the word address; held stable until a cycle with waitrequest=0, then enter W0/W1.
REQ-021 W0/W1: wait for readdatavalid=1, capture readdata; W0 goes to RD1, W1 goes to CHECK; at most one read outstanding.
REQ-022 CHECK, one cycle: pass iff bpp is in {8,16,24,32} with its BPP_EN bit set, 1<=xres<=MAX_XRES, 1<=yres<=MAX_YRES, and vmode[7:0]==FB_VMODE_NONINTERLACED[7:0]; all compares unsigned 32-bit.
REQ-023 WR: write=1, address = word2, writedata[31:0] = 0 on pass else 32'hFFFFFFEA; writedata[63:32] = xres rounded up to a multiple of 2**ALIGN_LOG2 on pass, else 0; held until waitrequest=0.
REQ-024 NEXT: increment the fail counter (16-bit, saturating) on fail; increment the index; go to RD0 if index < count, else RET.
REQ-025 RET: done=1 and returndata = zero-extended fail count, both stable while stall=1; enter IDLE on the first cycle with stall=0.
REQ-026 read and write are never both high; both are 0 outside RD*/WR.
REQ-027 start while busy=1 is ignored.
REQ-028 readdatavalid outside W0/W1 is ignored.
REQ-029 Latency per descriptor with zero waitrequest and 1-cycle read latency: 7 cycles.

Reset
REQ-030 resetn=0 forces IDLE and sets busy, done, read, write=0, returndata=0, address=0, writedata=0; counters cleared.
REQ-031 Reset mid-transaction abandons any bus transaction without completing it; the block issues no further bus cycles until a new start.

Verification
REQ-032 count=1, base=0x1000, word0={768,1024}, word1={0,16}, FB_VMODE_NONINTERLACED=0 -> one write to 0x1010 with data {1024,0}; done with returndata=0.
REQ-033 count=3, descriptor 1 has bpp=15 -> descriptor 1's word2 = {0,0xFFFFFFEA}; returndata=1; three writes at base+16, +40, +64.
REQ-034 xres=1601 fails; xres=1001 with ALIGN_LOG2=3 passes with xres_virtual=1008; vmode=1 fails.
REQ-035 waitrequest held for 5 cycles on each read and write, with random readdatavalid delay -> address and read/write remain stable; results identical to zero-wait runs.
REQ-036 arg_count=0 -> no bus activity; done on the next cycle with returndata=0; stall=1 for 4 cycles keeps done high and returndata constant.
REQ-037 resetn pulsed low during W1 of descriptor 2 -> all outputs go to 0 immediately; a subsequent start completes normally.
